// File: rtl/vector_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_issue_sequencer
// Purpose  : Queues APU-offloaded vector instructions and steps each one
//            through per-beat register addresses, element masks and last flag.
// Revision : 1.0
// ============================================================================
module vector_issue_sequencer #(
    parameter int LANES  = 4,
    parameter int VL_W   = 5,
    parameter int QDEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             apu_req,
    output logic             apu_gnt,
    input  logic [31:0]      apu_instr,
    input  logic [31:0]      apu_op_a,
    input  logic [31:0]      apu_op_b,
    input  logic [VL_W-1:0]  vl,
    input  logic [1:0]       vsew,
    output logic             beat_valid,
    input  logic             beat_ready,
    output logic             beat_last,
    output logic [VL_W-1:0]  beat_idx,
    output logic [4:0]       vs1_addr,
    output logic [4:0]       vs2_addr,
    output logic [4:0]       vd_addr,
    output logic [LANES-1:0] elem_mask,
    output logic [31:0]      instr_o,
    output logic [31:0]      scalar_a,
    output logic [31:0]      scalar_b,
    output logic             apu_rvalid,
    output logic             busy
);

    localparam int c_LOG2L = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int c_PTR_W = $clog2(QDEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_MW    = VL_W + 3;
    localparam int c_SW    = (VL_W > 5) ? VL_W : 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_CFG_GAP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        C_STEP   = 3'd0,
        C_FIXED  = 3'd1,
        C_SINGLE = 3'd2,
        C_CFG    = 3'd3,
        C_UNK    = 3'd4
    } cls_t;

    function automatic cls_t classify(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [5:0] f6);
        cls_t c;
        c = C_UNK;
        if (opc == 7'h57) begin
            if (f3 == 3'd7)
                c = C_CFG;
            else if ((f3 == 3'd2 && (f6 == 6'b000000 || f6 == 6'b000111)) || f6 == 6'b110001)
                c = C_FIXED;
            else if (f6 == 6'b010000)
                c = C_SINGLE;
            else
                c = C_STEP;
        end else if (opc == 7'h27 && f3 == 3'd7) begin
            c = C_FIXED;
        end else if (opc == 7'h07 && f3 == 3'd7) begin
            c = C_STEP;
        end
        return c;
    endfunction

    state_t               r_state, w_state_nxt;
    logic [95:0]          r_q [QDEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count, w_count_nxt;
    logic                 r_gnt;
    logic [31:0]          r_instr, r_op_a, r_op_b;
    logic [VL_W-1:0]      r_vl;
    logic [1:0]           r_vsew;
    cls_t                 r_cls;
    logic [VL_W-1:0]      r_beat_idx;
    logic [4:0]           r_vs1, r_vs2, r_vd;
    logic [LANES-1:0]     r_mask;
    logic                 r_last;

    logic                 w_enq, w_deq, w_adv, w_nonempty;
    logic [95:0]          w_head;
    cls_t                 w_sel_cls;
    logic [VL_W-1:0]      w_sel_vl, w_sel_idx, w_nbm1;
    logic [1:0]           w_sel_vsew;
    logic [4:0]           w_sel_rs1, w_sel_rs2, w_sel_rd, w_step;
    logic [c_SW-1:0]      w_idx_ext;
    logic [LANES-1:0]     w_mask;

    assign w_nonempty  = (r_count != '0);
    assign w_enq       = apu_req & r_gnt;
    assign w_head      = r_q[r_rd_ptr];
    assign w_count_nxt = r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_deq);

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q[r_wr_ptr] <= {apu_instr, apu_op_a, apu_op_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_gnt    <= 1'b1;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= w_count_nxt;
            r_gnt   <= (w_count_nxt != c_CNT_W'(QDEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // A config instruction always detours through CFG_GAP so the next dequeue sees the new vl.
    always_comb begin
        w_state_nxt = r_state;
        w_deq       = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE, S_CFG_GAP: begin
                if (w_nonempty) begin
                    w_deq       = 1'b1;
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EXEC: begin
                if (beat_ready) begin
                    if (!r_last) begin
                        w_adv = 1'b1;
                    end else if (r_cls == C_CFG) begin
                        w_state_nxt = S_CFG_GAP;
                    end else if (w_nonempty) begin
                        w_deq = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operands for the beat to be registered next: a fresh instruction or the following beat.
    always_comb begin
        w_sel_cls  = r_cls;
        w_sel_vl   = r_vl;
        w_sel_vsew = r_vsew;
        w_sel_idx  = r_beat_idx + VL_W'(1);
        w_sel_rs1  = r_instr[19:15];
        w_sel_rs2  = r_instr[24:20];
        w_sel_rd   = r_instr[11:7];
        if (w_deq) begin
            w_sel_cls  = classify(w_head[70:64], w_head[78:76], w_head[95:90]);
            w_sel_vl   = vl;
            w_sel_vsew = vsew;
            w_sel_idx  = '0;
            w_sel_rs1  = w_head[83:79];
            w_sel_rs2  = w_head[88:84];
            w_sel_rd   = w_head[75:71];
        end
    end

    always_comb begin
        w_idx_ext = c_SW'(w_sel_idx);
        w_step    = (w_sel_cls == C_STEP) ? 5'(w_idx_ext << w_sel_vsew) : 5'd0;
        w_nbm1    = '0;
        if ((w_sel_cls == C_STEP || w_sel_cls == C_FIXED) && w_sel_vl != '0) begin
            w_nbm1 = (w_sel_vl - VL_W'(1)) >> c_LOG2L;
        end
        w_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_mask[i] = ((c_MW'(w_sel_idx) << c_LOG2L) + c_MW'(i)) < c_MW'(w_sel_vl);
        end
        if (w_sel_cls == C_UNK) w_mask = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_vl       <= '0;
            r_vsew     <= '0;
            r_cls      <= C_STEP;
            r_beat_idx <= '0;
            r_vs1      <= '0;
            r_vs2      <= '0;
            r_vd       <= '0;
            r_mask     <= '0;
            r_last     <= 1'b0;
        end else if (w_deq || w_adv) begin
            r_beat_idx <= w_sel_idx;
            r_vs1      <= w_sel_rs1 + w_step;
            r_vs2      <= w_sel_rs2 + w_step;
            r_vd       <= w_sel_rd + w_step;
            r_mask     <= w_mask;
            r_last     <= (w_sel_idx == w_nbm1);
            if (w_deq) begin
                r_instr <= w_head[95:64];
                r_op_a  <= w_head[63:32];
                r_op_b  <= w_head[31:0];
                r_vl    <= vl;
                r_vsew  <= vsew;
                r_cls   <= w_sel_cls;
            end
        end
    end

    assign apu_gnt    = r_gnt;
    assign beat_valid = (r_state == S_EXEC);
    assign beat_last  = r_last;
    assign beat_idx   = r_beat_idx;
    assign vs1_addr   = r_vs1;
    assign vs2_addr   = r_vs2;
    assign vd_addr    = r_vd;
    assign elem_mask  = r_mask;
    assign instr_o    = r_instr;
    assign scalar_a   = r_op_a;
    assign scalar_b   = r_op_b;
    assign apu_rvalid = beat_valid & beat_ready & r_last;
    assign busy       = w_nonempty | (r_state == S_EXEC);

endmodule
`default_nettype wire

// File: tb/tb_vector_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_issue_sequencer
// Purpose  : Directed bench with a queue-level reference model and literal checks.
// Revision : 1.0
// ============================================================================
module tb_vector_issue_sequencer;

    localparam int L  = 4;
    localparam int VW = 5;
    localparam int QD = 2;

    logic          clk = 1'b0;
    logic          reset, apu_req, beat_ready;
    logic [31:0]   apu_instr, apu_op_a, apu_op_b;
    logic [VW-1:0] vl;
    logic [1:0]    vsew;
    logic          apu_gnt, beat_valid, beat_last, apu_rvalid, busy;
    logic [VW-1:0] beat_idx;
    logic [4:0]    vs1_addr, vs2_addr, vd_addr;
    logic [L-1:0]  elem_mask;
    logic [31:0]   instr_o, scalar_a, scalar_b;

    vector_issue_sequencer #(.LANES(L), .VL_W(VW), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset), .apu_req(apu_req), .apu_gnt(apu_gnt),
        .apu_instr(apu_instr), .apu_op_a(apu_op_a), .apu_op_b(apu_op_b),
        .vl(vl), .vsew(vsew), .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_last(beat_last), .beat_idx(beat_idx), .vs1_addr(vs1_addr),
        .vs2_addr(vs2_addr), .vd_addr(vd_addr), .elem_mask(elem_mask),
        .instr_o(instr_o), .scalar_a(scalar_a), .scalar_b(scalar_b),
        .apu_rvalid(apu_rvalid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rvalid = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr, a, b;
        logic [4:0]  idx, vs1, vs2, vd;
        logic [3:0]  mask;
        logic        last;
    } mb_t;

    typedef struct {
        int          cyc;
        logic [31:0] instr;
        logic [4:0]  idx, vs1, vs2, vd;
        logic [3:0]  mask;
        logic        last;
    } lg_t;

    logic [95:0] mq[$];
    mb_t         mbeats[$];
    lg_t         lg[$];
    bit          m_exec = 0, m_gnt = 1, m_on = 0, m_cfg = 0;
    bit          m_enq, m_start;
    logic [95:0] m_e;

    task automatic build(input logic [95:0] e, input int vlv, input int sew);
        logic [31:0] ins;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [5:0]  f6;
        bit single, fixed, unk, cfg;
        int n, step;
        mb_t bt;
        ins = e[95:64]; op = ins[6:0]; f3 = ins[14:12]; f6 = ins[31:26];
        single = 0; fixed = 0; unk = 0; cfg = 0;
        if (op == 7'h57 && f3 == 3'd7) begin cfg = 1; single = 1; end
        else if (op == 7'h27 && f3 == 3'd7) fixed = 1;
        else if (op == 7'h07 && f3 == 3'd7) fixed = 0;
        else if (op == 7'h57) begin
            if ((f3 == 3'd2 && (f6 == 6'd0 || f6 == 6'd7)) || f6 == 6'b110001) fixed = 1;
            else if (f6 == 6'b010000) single = 1;
        end else begin unk = 1; single = 1; end
        n = single ? 1 : ((vlv == 0) ? 1 : (vlv + L - 1) / L);
        for (int b = 0; b < n; b++) begin
            step = (single || fixed) ? 0 : ((b << sew) % 32);
            bt.instr = ins; bt.a = e[63:32]; bt.b = e[31:0];
            bt.idx  = 5'(b);
            bt.vs1  = 5'((int'(ins[19:15]) + step) % 32);
            bt.vs2  = 5'((int'(ins[24:20]) + step) % 32);
            bt.vd   = 5'((int'(ins[11:7]) + step) % 32);
            for (int i = 0; i < L; i++) bt.mask[i] = !unk && (b * L + i < vlv);
            bt.last = (b == n - 1);
            mbeats.push_back(bt);
        end
        m_cfg = cfg;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete(); mbeats.delete();
            m_exec = 0; m_gnt = 1; m_on = 1;
        end else begin
            m_enq   = apu_req && m_gnt;
            m_start = 0;
            if (m_exec) begin
                if (beat_ready) begin
                    void'(mbeats.pop_front());
                    if (mbeats.size() == 0) begin
                        m_exec = 0;
                        if (!m_cfg && mq.size() != 0) m_start = 1;
                    end
                end
            end else if (mq.size() != 0) begin
                m_start = 1;
            end
            if (m_start) begin
                m_e = mq.pop_front();
                build(m_e, int'(vl), int'(vsew));
                m_exec = 1;
            end
            if (m_enq) mq.push_back({apu_instr, apu_op_a, apu_op_b});
            m_gnt = (mq.size() < QD);
        end
    end

    // compare process
    always @(negedge clk) begin
        if (apu_rvalid) n_rvalid++;
        if (beat_valid && beat_ready)
            lg.push_back('{cyc, instr_o, beat_idx, vs1_addr, vs2_addr, vd_addr, elem_mask, beat_last});
        if (m_on) begin
            chk("beat_valid", beat_valid, m_exec);
            chk("apu_gnt", apu_gnt, m_gnt);
            chk("busy", busy, (mq.size() != 0) || m_exec);
            chk("apu_rvalid", apu_rvalid, m_exec && beat_ready && mbeats.size() == 1);
            if (m_exec && beat_valid) begin
                chk("beat_idx", beat_idx, mbeats[0].idx);
                chk("vs1_addr", vs1_addr, mbeats[0].vs1);
                chk("vs2_addr", vs2_addr, mbeats[0].vs2);
                chk("vd_addr", vd_addr, mbeats[0].vd);
                chk("elem_mask", elem_mask, mbeats[0].mask);
                chk("beat_last", beat_last, mbeats[0].last);
                chk("instr_o", instr_o, mbeats[0].instr);
                chk("scalar_a", scalar_a, mbeats[0].a);
                chk("scalar_b", scalar_b, mbeats[0].b);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] enc(input logic [5:0] f6, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f6, 1'b1, rs2, rs1, f3, rd, op};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        output int refused);
        logic g;
        refused = 0;
        apu_req = 1; apu_instr = ins; apu_op_a = a; apu_op_b = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); g = apu_gnt;
            @(posedge clk); #1;
            if (g) begin apu_req = 0; return; end
            refused++;
        end
        apu_req = 0;
        chk("send_timeout", 1'b1, 1'b0);
    endtask

    task automatic wait_quiet(input int limit);
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #2;
            if (!busy) return;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    logic [31:0] i_x, i_y1, i_y2, i_y3, i_cfg;
    int r, rv0;
    bit found;

    initial begin
        reset = 1; apu_req = 0; apu_instr = 0; apu_op_a = 0; apu_op_b = 0;
        vl = 0; vsew = 0; beat_ready = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // reset while executing with two entries queued
        vl = 5'd31; vsew = 2'd0;
        send(enc(6'd0, 5'd8, 5'd12, 3'd0, 5'd4, 7'h57), 32'h11, 32'h22, r);
        send(enc(6'd0, 5'd9, 5'd13, 3'd0, 5'd5, 7'h57), 32'h33, 32'h44, r);
        send(enc(6'd0, 5'd10, 5'd14, 3'd0, 5'd6, 7'h57), 32'h55, 32'h66, r);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_gnt", apu_gnt, 1'b0);
        @(posedge clk); #1 reset = 1;
        tick(); tick();
        reset = 0;
        @(negedge clk);
        chk("rst_valid", beat_valid, 1'b0);
        chk("rst_last", beat_last, 1'b0);
        chk("rst_idx", beat_idx, 5'd0);
        chk("rst_addrs", {vs1_addr, vs2_addr, vd_addr}, 15'd0);
        chk("rst_mask", elem_mask, 4'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_scalars", {scalar_a, scalar_b}, 64'd0);
        chk("rst_gnt", apu_gnt, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rv0 = n_rvalid;
        @(posedge clk); #1 beat_ready = 1;
        repeat (12) tick();
        chk("rst_no_rvalid", 32'(n_rvalid - rv0), 32'd0);

        // vadd.vv v4,v8,v12 vl=10 e16
        vl = 5'd10; vsew = 2'd1; lg.delete();
        send(enc(6'd0, 5'd8, 5'd12, 3'd0, 5'd4, 7'h57), 32'hA, 32'hB, r);
        wait_quiet(50);
        chk("vadd_beats", lg.size(), 3);
        chk("vadd_vd", {lg[0].vd, lg[1].vd, lg[2].vd}, {5'd4, 5'd6, 5'd8});
        chk("vadd_vs2", {lg[0].vs2, lg[1].vs2, lg[2].vs2}, {5'd8, 5'd10, 5'd12});
        chk("vadd_mask", {lg[0].mask, lg[1].mask, lg[2].mask}, 12'hFF3);
        chk("vadd_last", {lg[0].last, lg[1].last, lg[2].last}, 3'b001);

        // reduction vredsum, vl=7
        vl = 5'd7; vsew = 2'd2; lg.delete();
        send(enc(6'd0, 5'd6, 5'd3, 3'd2, 5'd2, 7'h57), 32'h1, 32'h2, r);
        wait_quiet(50);
        chk("red_beats", lg.size(), 2);
        chk("red_addrs", {lg[0].vd, lg[0].vs2, lg[1].vd, lg[1].vs2}, {5'd2, 5'd6, 5'd2, 5'd6});
        chk("red_mask", {lg[0].mask, lg[1].mask}, 8'hF7);

        // back-pressure on beat 1
        vl = 5'd16; vsew = 2'd0; lg.delete(); rv0 = n_rvalid;
        send(enc(6'd0, 5'd8, 5'd12, 3'd0, 5'd4, 7'h57), 32'h7, 32'h8, r);
        tick(); tick();
        beat_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_idx", beat_idx, 5'd1);
            chk("bp_vd", vd_addr, 5'd5);
            chk("bp_rvalid", apu_rvalid, 1'b0);
            @(posedge clk); #1;
        end
        beat_ready = 1;
        wait_quiet(50);
        chk("bp_beats", lg.size(), 4);
        chk("bp_tail_rate", 32'(lg[3].cyc - lg[1].cyc), 32'd2);
        chk("bp_rvalids", 32'(n_rvalid - rv0), 32'd1);

        // queue fill during a long instruction
        vl = 5'd31; vsew = 2'd0; lg.delete();
        i_x  = enc(6'd0, 5'd1, 5'd2, 3'd0, 5'd0, 7'h57);
        i_y1 = enc(6'd0, 5'd1, 5'd2, 3'd0, 5'd8, 7'h57);
        i_y2 = enc(6'd0, 5'd1, 5'd2, 3'd0, 5'd16, 7'h57);
        i_y3 = enc(6'd0, 5'd1, 5'd2, 3'd0, 5'd24, 7'h57);
        send(i_x, 32'h0, 32'h0, r);
        send(i_y1, 32'h1, 32'h1, r);
        send(i_y2, 32'h2, 32'h2, r);
        send(i_y3, 32'h3, 32'h3, r);
        chk("fill_refused", r, 7);
        wait_quiet(100);
        chk("fill_beats", lg.size(), 32);
        chk("fill_order", {lg[8].instr, lg[16].instr, lg[24].instr}, {i_y1, i_y2, i_y3});
        chk("fill_nobubble", 32'(lg[31].cyc - lg[0].cyc), 32'd31);

        // vsetvli then vadd: vl 4 -> 8 on the config completion
        vl = 5'd4; vsew = 2'd0; lg.delete(); found = 0;
        i_cfg = enc(6'd0, 5'd0, 5'd2, 3'd7, 5'd1, 7'h57);
        send(i_cfg, 32'h0, 32'h0, r);
        send(enc(6'd0, 5'd8, 5'd12, 3'd0, 5'd4, 7'h57), 32'h9, 32'h9, r);
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (apu_rvalid) found = 1;
        end
        chk("cfg_rvalid_seen", found, 1'b1);
        @(posedge clk); #1 vl = 5'd8;
        wait_quiet(50);
        chk("cfg_beats", lg.size(), 3);
        chk("cfg_first", lg[0].instr, i_cfg);
        chk("cfg_gap", 32'(lg[1].cyc - lg[0].cyc), 32'd2);
        chk("cfg_vadd_mask", {lg[1].mask, lg[2].mask, lg[2].last}, 9'h1FF);

        // boundary and remaining classes
        vl = 5'd0; lg.delete();
        send(enc(6'd0, 5'd8, 5'd12, 3'd0, 5'd4, 7'h57), 32'h0, 32'h0, r);
        wait_quiet(50);
        chk("vl0", {lg.size() == 1, lg[0].mask, lg[0].last}, 6'b1_0000_1);

        vl = 5'd10; lg.delete();
        send(32'h0020_81B3, 32'h5, 32'h6, r);
        wait_quiet(50);
        chk("unknown", {lg.size() == 1, lg[0].mask, lg[0].last}, 6'b1_0000_1);

        vsew = 2'd2; lg.delete();
        send(enc(6'd0, 5'd0, 5'd3, 3'd7, 5'd30, 7'h07), 32'h100, 32'h0, r);
        wait_quiet(50);
        chk("load_wrap", {lg[0].vd, lg[1].vd, lg[2].vd}, {5'd30, 5'd2, 5'd6});

        lg.delete();
        send(enc(6'd0, 5'd4, 5'd3, 3'd7, 5'd12, 7'h27), 32'h200, 32'h0, r);
        send(enc(6'b010000, 5'd7, 5'd0, 3'd2, 5'd5, 7'h57), 32'h0, 32'h0, r);
        wait_quiet(50);
        chk("store_vmv", {lg.size() == 4, lg[2].vd, lg[3].vs2, lg[3].last}, {1'b1, 5'd12, 5'd7, 1'b1});

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
